instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader_pkg.sv | 26 ++
 rtl/instr_loader_if.sv | 28 ++
 rtl/rv_instr_encoder.sv | 29 ++
 rtl/instr_loader.sv | 94 +++++++++
 tb/tb_instr_loader.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_loader_pkg.sv
// Shared constants for the instruction loader: opcodes, kind codes, FSM states.
// Pure declarations, no logic; no latency.
// No flow control here; users apply these codes on their own handshakes.
package instr_loader_pkg;

   // RV32I major opcodes used by the supported formats
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   // Bundle format selector
   typedef logic [1:0] kind_t;
   localparam kind_t KIND_R   = 2'b00;
   localparam kind_t KIND_LW  = 2'b01;
   localparam kind_t KIND_SW  = 2'b10;
   localparam kind_t KIND_BEQ = 2'b11;

   // Loader FSM states
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_LOAD  = 2'd1;
   localparam state_t ST_WRITE = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/instr_loader_if.sv
// Instruction-field bundle channel from a source into the loader.
// No storage; latency is that of the connected endpoints.
// Valid/ready: the master holds the bundle stable until in_valid && in_ready.
interface instr_loader_if;
   import instr_loader_pkg::*;

   logic        in_valid;
   logic        in_ready;
   kind_t       kind;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [2:0]  funct3;
   logic        funct7b5;
   logic [11:0] imm;
   logic        last;

   modport master (
      output in_valid, kind, rd, rs1, rs2, funct3, funct7b5, imm, last,
      input  in_ready
   );

   modport slave (
      input  in_valid, kind, rd, rs1, rs2, funct3, funct7b5, imm, last,
      output in_ready
   );

endinterface

// File: rtl/rv_instr_encoder.sv
// Packs R-type/lw/sw/beq instruction fields into a 32-bit RV32I word.
// Purely combinational, zero latency.
// No flow control; the output follows the inputs.
module rv_instr_encoder
   import instr_loader_pkg::*;
(
   input  kind_t       kind,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic        funct7b5,
   input  logic [11:0] imm,
   output logic [31:0] word
);

   // Select the bit layout for the requested format; beq imm carries offset[12:1]
   always_comb begin
      word = '0;
      case (kind)
         KIND_R:   word = {(funct7b5 ? 7'b0100000 : 7'b0000000), rs2, rs1, funct3, rd, OP_R};
         KIND_LW:  word = {imm[11:0], rs1, 3'b010, rd, OP_LOAD};
         KIND_SW:  word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
         KIND_BEQ: word = {imm[11], imm[9:4], rs2, rs1, 3'b000, imm[3:0], imm[10], OP_BRANCH};
         default:  word = '0;
      endcase
   end

endmodule

// File: rtl/instr_loader.sv
// Accepts instruction-field bundles, encodes them and writes consecutive memory words.
// One cycle from bundle acceptance to mem_we; one word per two cycles at best.
// in_ready only in LOAD with space left; a bundle offered when full flags err and ends the session.
module instr_loader
   import instr_loader_pkg::*;
#(
   parameter int          DEPTH     = 64,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   instr_loader_if.slave                bus,
   output logic                         mem_we,
   output logic [31:0]                  mem_addr,
   output logic [31:0]                  mem_wdata,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         done,
   output logic                         err
);

   localparam int             CW      = $clog2(DEPTH + 1);
   localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

   state_t         state;
   logic [CW-1:0]  count_q;
   logic [31:0]    word_q;
   logic           last_q;
   logic           err_q;
   logic [31:0]    enc_word;
   logic           xfer;
   logic           overflow;

   rv_instr_encoder u_enc (
      .kind     (bus.kind),
      .rd       (bus.rd),
      .rs1      (bus.rs1),
      .rs2      (bus.rs2),
      .funct3   (bus.funct3),
      .funct7b5 (bus.funct7b5),
      .imm      (bus.imm),
      .word     (enc_word)
   );

   // Handshake and outputs decoded from state so reset clears them immediately
   always_comb begin
      bus.in_ready = (state == ST_LOAD) && (count_q < DEPTH_C);
      xfer         = bus.in_ready && bus.in_valid;
      overflow     = (state == ST_LOAD) && (count_q == DEPTH_C) && bus.in_valid;
      mem_we       = (state == ST_WRITE);
      mem_addr     = mem_we ? (BASE_ADDR + (32'(count_q) << 2)) : 32'h0;
      mem_wdata    = mem_we ? word_q : 32'h0;
      count        = count_q;
      done         = (state == ST_DONE);
      err          = err_q;
   end

   // Session FSM: capture a bundle, write it next cycle, stop on last or overflow
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         count_q <= '0;
         word_q  <= '0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state   <= ST_LOAD;
                  count_q <= '0;
                  err_q   <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (xfer) begin
                  word_q <= enc_word;
                  last_q <= bus.last;
                  state  <= ST_WRITE;
               end else if (overflow) begin
                  err_q <= 1'b1;
                  state <= ST_DONE;
               end
            end
            ST_WRITE: begin
               count_q <= count_q + CW'(1);
               state   <= last_q ? ST_DONE : ST_LOAD;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader (DEPTH=4): directed vectors, corner sequences, random sessions.
// Outputs sampled on the falling edge; inputs also changed there.
// Source holds each bundle until accepted.
module tb_instr_loader;

   localparam int DEPTH = 4;

   typedef struct {
      logic [1:0]  kind;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic        f7;
      logic [11:0] imm;
      logic        last;
      logic [31:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [2:0]  count;
   logic        done;
   logic        err;

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_data_q[$];

   instr_loader_if bus();

   instr_loader #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .bus       (bus),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .count     (count),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
      end
   endtask

   // Instruction words built from the ISA definition: branch offset is imm*2, scattered per B-type
   function automatic logic [31:0] ref_enc(input logic [1:0] k, input logic [4:0] rd,
         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
         input logic f7, input logic [11:0] imm);
      logic [31:0] r;
      logic [12:0] b;
      b = {imm, 1'b0};
      r = 32'(rs1) << 15;
      case (k)
         2'd0: r += (f7 ? 32'h4000_0000 : 32'h0) + (32'(rs2) << 20) + (32'(f3) << 12) + (32'(rd) << 7) + 32'h33;
         2'd1: r += (32'(imm) << 20) + (32'd2 << 12) + (32'(rd) << 7) + 32'h03;
         2'd2: r += (32'(imm >> 5) << 25) + (32'(rs2) << 20) + (32'd2 << 12) + (32'(imm & 12'h1F) << 7) + 32'h23;
         default: r += (32'(b[12]) << 31) + (32'(b[10:5]) << 25) + (32'(rs2) << 20)
                      + (32'(b[4:1]) << 8) + (32'(b[11]) << 7) + 32'h63;
      endcase
      return r;
   endfunction

   function automatic vec_t rand_vec(input logic lst);
      vec_t v;
      v.kind = 2'($urandom_range(0, 3));
      v.rd   = 5'($urandom);
      v.rs1  = 5'($urandom);
      v.rs2  = 5'($urandom);
      v.f3   = 3'($urandom);
      v.f7   = 1'($urandom);
      v.imm  = 12'($urandom);
      v.last = lst;
      v.exp  = ref_enc(v.kind, v.rd, v.rs1, v.rs2, v.f3, v.f7, v.imm);
      return v;
   endfunction

   // Scoreboard and always-on output rules
   always @(negedge clk) begin
      if (!mem_we) begin
         chk("idle_addr_zero", mem_addr, 32'h0);
         chk("idle_wdata_zero", mem_wdata, 32'h0);
      end else begin
         chk("write_in_ready_low", 32'(bus.in_ready), 32'h0);
         if (mon_en) begin
            if (exp_addr_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_write actual addr=%h data=%h required none", mem_addr, mem_wdata);
            end else begin
               chk("sb_addr", mem_addr, exp_addr_q.pop_front());
               chk("sb_data", mem_wdata, exp_data_q.pop_front());
            end
         end
      end
   end

   task automatic drive(input vec_t v);
      bus.kind = v.kind; bus.rd = v.rd; bus.rs1 = v.rs1; bus.rs2 = v.rs2;
      bus.funct3 = v.f3; bus.funct7b5 = v.f7; bus.imm = v.imm; bus.last = v.last;
   endtask

   // Present a bundle and hold it until accepted; returns at the falling edge of the write cycle
   task automatic offer(input vec_t v, output bit ok);
      ok = 1'b0;
      drive(v);
      bus.in_valid = 1'b1;
      for (int t = 0; t < 40; t++) begin
         if (bus.in_ready) begin
            ok = 1'b1;
            @(negedge clk);
            bus.in_valid = 1'b0;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         bus.in_valid = 1'b0;
         chk("accept_timeout", 32'h0, 32'h1);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      int t;
      for (t = 0; t < 20 && !done; t++) @(negedge clk);
      chk("done_reached", 32'(done), 32'h1);
   endtask

   vec_t tbl[7];

   initial begin
      bit ok;
      int sidx;

      tbl[0] = '{2'b01, 5'd5,  5'd1,  5'd0,  3'd0, 1'b0, 12'd8,     1'b0, 32'h0080A283};
      tbl[1] = '{2'b10, 5'd0,  5'd2,  5'd6,  3'd0, 1'b0, 12'd12,    1'b0, 32'h00612623};
      tbl[2] = '{2'b00, 5'd3,  5'd1,  5'd2,  3'd0, 1'b0, 12'd0,     1'b0, 32'h002081B3};
      tbl[3] = '{2'b00, 5'd1,  5'd2,  5'd3,  3'd0, 1'b1, 12'd0,     1'b1, 32'h403100B3};
      tbl[4] = '{2'b11, 5'd0,  5'd1,  5'd2,  3'd0, 1'b0, 12'hFFE,   1'b1, 32'hFE208EE3};
      tbl[5] = '{2'b01, 5'd31, 5'd31, 5'd0,  3'd0, 1'b0, 12'hFFF,   1'b0, 32'hFFFFAF83};
      tbl[6] = '{2'b10, 5'd0,  5'd0,  5'd31, 3'd0, 1'b0, 12'h800,   1'b1, 32'h81F02023};

      rst = 1'b0;
      start = 1'b0;
      bus.in_valid = 1'b0;
      drive(tbl[0]);

      // Reset state
      @(negedge clk); @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
      chk("rst_mem_we", 32'(mem_we), 32'h0);
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_idle_ready", 32'(bus.in_ready), 32'h0);
      chk("post_rst_idle_done", 32'(done), 32'h0);

      // Directed vectors; a new session starts after each last
      sidx = 0;
      for (int i = 0; i < 7; i++) begin
         if (i == 0 || tbl[i-1].last) begin
            pulse_start();
            sidx = 0;
            chk("sess_count_clear", 32'(count), 32'h0);
            chk("sess_done_clear", 32'(done), 32'h0);
            chk("sess_in_ready", 32'(bus.in_ready), 32'h1);
         end
         offer(tbl[i], ok);
         if (ok) begin
            chk("vec_mem_we", 32'(mem_we), 32'h1);
            chk("vec_addr", mem_addr, 32'(sidx * 4));
            chk("vec_wdata", mem_wdata, tbl[i].exp);
            sidx++;
         end
         if (tbl[i].last) begin
            wait_done();
            chk("vec_count", 32'(count), 32'(sidx));
            chk("vec_err", 32'(err), 32'h0);
         end
      end

      // Overflow: four writes fill memory, fifth bundle flags err without writing
      @(negedge clk);
      pulse_start();
      for (int i = 0; i < DEPTH; i++) begin
         vec_t v;
         v = rand_vec(1'b0);
         offer(v, ok);
         chk("ovf_addr", mem_addr, 32'(i * 4));
         chk("ovf_wdata", mem_wdata, v.exp);
      end
      @(negedge clk);
      drive(rand_vec(1'b0));
      bus.in_valid = 1'b1;
      chk("full_in_ready", 32'(bus.in_ready), 32'h0);
      chk("full_count", 32'(count), 32'(DEPTH));
      @(negedge clk);
      chk("ovf_done", 32'(done), 32'h1);
      chk("ovf_err", 32'(err), 32'h1);
      chk("ovf_no_write", 32'(mem_we), 32'h0);
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("ovf_err_hold", 32'(err), 32'h1);
      pulse_start();
      chk("restart_err", 32'(err), 32'h0);
      chk("restart_done", 32'(done), 32'h0);
      chk("restart_count", 32'(count), 32'h0);
      offer(tbl[4], ok);
      wait_done();

      // Reset in the middle of a write drops it; held valid without start is ignored
      @(negedge clk);
      pulse_start();
      offer(tbl[0], ok);
      chk("pre_rst_we", 32'(mem_we), 32'h1);
      #2 rst = 1'b0;
      #1;
      chk("arst_mem_we", 32'(mem_we), 32'h0);
      chk("arst_count", 32'(count), 32'h0);
      chk("arst_in_ready", 32'(bus.in_ready), 32'h0);
      chk("arst_addr", mem_addr, 32'h0);
      bus.in_valid = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("held_valid_no_ready", 32'(bus.in_ready), 32'h0);
         chk("held_valid_no_we", 32'(mem_we), 32'h0);
      end
      bus.in_valid = 1'b0;

      // Random sessions against the scoreboard
      mon_en = 1'b1;
      for (int s = 0; s < 40; s++) begin
         vec_t vs[$];
         int n, k;
         bit ovf;
         if ($urandom_range(0, 3) != 0) begin
            n = $urandom_range(1, DEPTH);
            k = $urandom_range(1, n);
            ovf = 1'b0;
         end else begin
            n = DEPTH + 1;
            k = DEPTH;
            ovf = 1'b1;
         end
         vs = {};
         for (int i = 0; i < n; i++) vs.push_back(rand_vec(!ovf && (i == k - 1)));
         for (int i = 0; i < k; i++) begin
            exp_addr_q.push_back(32'(i * 4));
            exp_data_q.push_back(vs[i].exp);
         end
         pulse_start();
         for (int i = 0; i <= k; i++) begin
            if (i == k && !ovf) break;
            repeat ($urandom_range(0, 2)) begin
               bus.in_valid = 1'b0;
               start = 1'($urandom_range(0, 1));
               @(negedge clk);
               start = 1'b0;
            end
            if (i < k) offer(vs[i], ok);
            else begin
               drive(vs[i]);
               bus.in_valid = 1'b1;
            end
         end
         wait_done();
         bus.in_valid = 1'b0;
         chk("rand_err", 32'(err), 32'(ovf));
         chk("rand_count", 32'(count), 32'(k));
         chk("rand_sb_empty", 32'(exp_addr_q.size()), 32'h0);
         exp_addr_q = {};
         exp_data_q = {};
         @(negedge clk);
      end
      mon_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
